brush_writer: RTL and testbench

- Write-side engine for the 90x90 pixel canvas RAM.
- Accepts paint commands (square brush stamp or full canvas clear) over a valid/ready handshake.
- Sequences them into one-pixel-per-cycle writes on the RAM write port, driving the write strobe, write coordinates and write colour.
- Sits between the cursor/input controller and the pixel store; the VGA read path is untouched.

---
 rtl/brush_pkg.sv | 8 +
 rtl/brush_writer_raster_counter.sv | 62 ++++++
 rtl/brush_writer.sv | 110 +++++++++++
 tb/tb_brush_writer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/brush_pkg.sv
// Shared types and constants for the canvas write-side engine.
package brush_pkg;
   localparam int unsigned CANVAS_SIZE  = 90;
   localparam logic [2:0]  BORDER_COLOR = 3'b101;

   typedef enum logic [1:0] {IDLE, STAMP, CLEAR} brush_state_t;
   typedef logic [2:0] color_t;
endpackage

// File: rtl/brush_writer_raster_counter.sv
// 2-D raster counter: x steps fastest from a loadable start to a loadable end, then y.
// x_next/y_next expose the position the counter will hold after this edge.
module raster_counter #(
   parameter int unsigned W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         step,
   input  logic [W-1:0] x_start,
   input  logic [W-1:0] y_start,
   input  logic [W-1:0] x_end,
   input  logic [W-1:0] y_end,
   output logic [W-1:0] x_next,
   output logic [W-1:0] y_next,
   output logic         last
);
   logic [W-1:0] x_q, y_q, xs_q, xe_q, ye_q;
   logic [W-1:0] x_d, y_d, xs_d, xe_d, ye_d;

   always_comb begin
      xs_d = xs_q;
      xe_d = xe_q;
      ye_d = ye_q;
      x_d  = x_q;
      y_d  = y_q;
      if (load) begin
         xs_d = x_start;
         xe_d = x_end;
         ye_d = y_end;
         x_d  = x_start;
         y_d  = y_start;
      end else if (step) begin
         if (x_q == xe_q) begin
            x_d = xs_q;
            y_d = y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q  <= '0;
         y_q  <= '0;
         xs_q <= '0;
         xe_q <= '0;
         ye_q <= '0;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         xs_q <= xs_d;
         xe_q <= xe_d;
         ye_q <= ye_d;
      end
   end

   assign x_next = x_d;
   assign y_next = y_d;
   assign last   = (x_q == xe_q) && (y_q == ye_q);
endmodule

// File: rtl/brush_writer.sv
// Canvas write engine: turns stamp/clear commands into one-pixel-per-cycle RAM writes.
// Output registers are loaded from the counter's next position, so the first pixel shows the cycle after accept.
module brush_writer
   import brush_pkg::*;
#(
   parameter int unsigned CANVAS      = CANVAS_SIZE,
   parameter logic [2:0]  CLEAR_COLOR = 3'b000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmdValid,
   output logic       cmdReady,
   input  logic       cmdClear,
   input  logic [7:0] cx,
   input  logic [7:0] cy,
   input  logic [1:0] radius,
   input  logic [2:0] color,
   output logic       brush,
   output logic [7:0] wx,
   output logic [7:0] wy,
   output logic [2:0] newColor,
   output logic       busy
);
   brush_state_t state_q, state_d;
   color_t       col_q, col_d, newColor_q, newColor_d;
   logic         brush_q, brush_d, busy_q, busy_d;
   logic [7:0]   wx_q, wx_d, wy_q, wy_d;

   logic       accept, scanning, last, scan_d, in_bounds;
   logic [8:0] xs, ys, xe, ye, nx, ny;

   assign accept   = cmdValid && (state_q == IDLE);
   assign scanning = (state_q != IDLE);

   // Window bounds in 9-bit signed so clipped edges fall below zero.
   always_comb begin
      if (cmdClear) begin
         xs = '0;
         ys = '0;
         xe = 9'(CANVAS - 1);
         ye = 9'(CANVAS - 1);
      end else begin
         xs = {1'b0, cx} - {7'b0, radius};
         ys = {1'b0, cy} - {7'b0, radius};
         xe = {1'b0, cx} + {7'b0, radius};
         ye = {1'b0, cy} + {7'b0, radius};
      end
   end

   raster_counter #(.W(9)) u_counter (
      .clk     (clk),
      .rst_n   (reset),
      .load    (accept),
      .step    (scanning && !last),
      .x_start (xs),
      .y_start (ys),
      .x_end   (xe),
      .y_end   (ye),
      .x_next  (nx),
      .y_next  (ny),
      .last    (last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         col_q      <= '0;
         brush_q    <= 1'b0;
         busy_q     <= 1'b0;
         wx_q       <= '0;
         wy_q       <= '0;
         newColor_q <= '0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         brush_q    <= brush_d;
         busy_q     <= busy_d;
         wx_q       <= wx_d;
         wy_q       <= wy_d;
         newColor_q <= newColor_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:         if (accept) state_d = cmdClear ? CLEAR : STAMP;
         STAMP, CLEAR: if (last) state_d = IDLE;
         default:      state_d = IDLE;
      endcase
   end

   always_comb begin
      cmdReady   = (state_q == IDLE);
      scan_d     = accept || (scanning && !last);
      in_bounds  = !nx[8] && (nx[7:0] < 8'(CANVAS)) && !ny[8] && (ny[7:0] < 8'(CANVAS));
      col_d      = accept ? (cmdClear ? CLEAR_COLOR : color) : col_q;
      busy_d     = scan_d;
      brush_d    = scan_d && in_bounds;
      wx_d       = brush_d ? nx[7:0] : wx_q;
      wy_d       = brush_d ? ny[7:0] : wy_q;
      newColor_d = brush_d ? col_d : newColor_q;
   end

   assign brush    = brush_q;
   assign wx       = wx_q;
   assign wy       = wy_q;
   assign newColor = newColor_q;
   assign busy     = busy_q;
endmodule

// File: tb/tb_brush_writer.sv
// Scoreboard bench for brush_writer: the driver queues one expected record per scan cycle,
// a negedge monitor pops and compares whenever busy is high.
module tb_brush_writer;
   localparam int CAN = 90;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmdValid = 1'b0, cmdClear = 1'b0;
   logic [7:0] cx = '0, cy = '0;
   logic [1:0] radius = '0;
   logic [2:0] color = '0;
   logic       cmdReady, brush, busy;
   logic [7:0] wx, wy;
   logic [2:0] newColor;

   brush_writer #(.CANVAS(90), .CLEAR_COLOR(3'b000)) dut (
      .clk(clk), .reset(rst_n), .cmdValid(cmdValid), .cmdReady(cmdReady),
      .cmdClear(cmdClear), .cx(cx), .cy(cy), .radius(radius), .color(color),
      .brush(brush), .wx(wx), .wy(wy), .newColor(newColor), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {bit br; int x; int y; int c; bit last;} rec_t;
   rec_t q[$];
   int   errors = 0, checks = 0;
   bit   mon_en = 1'b0;

   // Reference: every position of the command in raster order, pixel written iff on canvas.
   task automatic model(input bit clr, input int mx, input int my, input int r, input int c);
      rec_t e;
      if (clr) begin
         for (int y = 0; y < CAN; y++)
            for (int x = 0; x < CAN; x++) begin
               e = '{1'b1, x, y, 0, (x == CAN-1 && y == CAN-1)};
               q.push_back(e);
            end
      end else begin
         for (int y = my - r; y <= my + r; y++)
            for (int x = mx - r; x <= mx + r; x++) begin
               e.br = (x >= 0 && x < CAN && y >= 0 && y < CAN);
               e.x = x; e.y = y; e.c = c;
               e.last = (x == mx + r && y == my + r);
               q.push_back(e);
            end
      end
   endtask

   task automatic send(input bit clr, input int mx, input int my, input int r, input int c,
                       input bit track);
      int n = 0;
      @(negedge clk);
      cmdValid = 1'b1; cmdClear = clr;
      cx = 8'(mx); cy = 8'(my); radius = 2'(r); color = 3'(c);
      while (!cmdReady && n < 20000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!cmdReady) begin
         errors++;
         $display("FAIL accept_timeout: cmdReady=%0b required=1", cmdReady);
      end else begin
         if (track) model(clr, mx, my, r, c);
         @(posedge clk);
         @(negedge clk);
      end
      cmdValid = 1'b0;
      cmdClear = 1'($urandom);
      cx = 8'($urandom); cy = 8'($urandom);
      radius = 2'($urandom); color = 3'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || busy) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (q.size() != 0 || busy) begin
         errors++;
         $display("FAIL drain: pending=%0d busy=%0b required 0/0", q.size(), busy);
      end
   endtask

   initial begin : monitor
      rec_t e;
      bit   expect_idle = 1'b0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            expect_idle = 1'b0;
         end else begin
            if (expect_idle) begin
               checks++;
               if (busy !== 1'b0) begin
                  errors++;
                  $display("FAIL busy_fall: busy=%0b required=0", busy);
               end
               expect_idle = 1'b0;
            end
            checks++;
            if (cmdReady !== !busy) begin
               errors++;
               $display("FAIL ready_vs_busy: cmdReady=%0b busy=%0b", cmdReady, busy);
            end
            if (busy) begin
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL overrun: busy=1 with no scan position expected");
               end else begin
                  e = q.pop_front();
                  if (brush !== e.br ||
                      (e.br && (int'(wx) != e.x || int'(wy) != e.y || int'(newColor) != e.c))) begin
                     errors++;
                     $display("FAIL scan: got brush=%0b (%0d,%0d) c=%0d required brush=%0b (%0d,%0d) c=%0d",
                              brush, wx, wy, newColor, e.br, e.x, e.y, e.c);
                  end
                  if (e.last) expect_idle = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #12;
      checks++;
      if (brush !== 1'b0 || wx !== 8'd0 || wy !== 8'd0 || newColor !== 3'd0 ||
          busy !== 1'b0 || cmdReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: brush=%0b wx=%0d wy=%0d c=%0d busy=%0b rdy=%0b required 0/0/0/0/0/1",
                  brush, wx, wy, newColor, busy, cmdReady);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1'b1;

      send(0, 10, 10, 1, 3, 1);
      drain();
      send(0, 0, 0, 2, 5, 1);
      send(0, 200, 200, 3, 2, 1);
      send(1, 0, 0, 0, 7, 1);
      send(0, 45, 88, 2, 6, 1);
      for (int i = 0; i < 24; i++) begin
         int mx, my;
         mx = ($urandom_range(0, 7) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 95);
         my = ($urandom_range(0, 7) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 95);
         send(0, mx, my, $urandom_range(0, 3), $urandom_range(0, 7), 1);
      end
      drain();

      // Reset while the 4th pixel of an r=2 stamp is on the outputs.
      mon_en = 1'b0;
      send(0, 30, 40, 2, 4, 0);
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (brush !== 1'b1 || wx !== 8'd31 || wy !== 8'd38) begin
         errors++;
         $display("FAIL pre_reset_write: brush=%0b (%0d,%0d) required 1 (31,38)", brush, wx, wy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (brush !== 1'b0 || wx !== 8'd0 || wy !== 8'd0 || newColor !== 3'd0 ||
          busy !== 1'b0 || cmdReady !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: brush=%0b wx=%0d wy=%0d c=%0d busy=%0b rdy=%0b required 0/0/0/0/0/1",
                  brush, wx, wy, newColor, busy, cmdReady);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         checks++;
         if (brush !== 1'b0 || busy !== 1'b0 || cmdReady !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: brush=%0b busy=%0b rdy=%0b required 0/0/1",
                     brush, busy, cmdReady);
         end
      end
      mon_en = 1'b1;
      send(0, 89, 0, 1, 1, 1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
